// File: rtl/wb_seq_master.sv
// Wishbone sequential write / read-back-check traffic master for the SDRAM responder.
// Optional ack watchdog enabled by defining WBM_TIMEOUT_EN.
module wb_seq_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [31:0] base_addr,
  input  logic [15:0] count,
  input  logic [31:0] seed,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy,
  output logic        done,
  output logic [15:0] err_cnt,
  output logic [31:0] first_err_addr,
  output logic        timeout_o
);

  typedef enum logic [2:0] {StIdle, StWr, StWgap, StRd, StRgap, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] k_q, k_d, count_q, count_d, err_q, err_d;
  logic [1:0]  mode_q, mode_d;
  logic [31:0] base_q, base_d, seed_q, seed_d, adr_q, adr_d, dat_q, dat_d, ferr_q, ferr_d;
  logic        cyc_q, cyc_d, we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic [3:0]  sel_q, sel_d;
  logic [15:0] k_inc;

`ifdef WBM_TIMEOUT_EN
  localparam int unsigned WdW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [WdW-1:0] wdog_q, wdog_d;
  logic           tmo_q, tmo_d;
`endif

  function automatic logic [31:0] addr_of(input logic [31:0] base, input logic [15:0] k);
    return base + {14'd0, k, 2'b00};
  endfunction

  assign k_inc = k_q + 16'd1;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    count_d = count_q;
    mode_d  = mode_q;
    base_d  = base_q;
    seed_d  = seed_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef WBM_TIMEOUT_EN
    wdog_d  = wdog_q;
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d  = mode;
          base_d  = base_addr;
          count_d = count;
          seed_d  = seed;
          k_d     = 16'd0;
          err_d   = 16'd0;
          ferr_d  = 32'd0;
`ifdef WBM_TIMEOUT_EN
          tmo_d   = 1'b0;
          wdog_d  = '0;
`endif
          if (mode == 2'b00 || count == 16'd0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            busy_d  = 1'b1;
            cyc_d   = 1'b1;
            we_d    = mode[0];
            adr_d   = base_addr;
            dat_d   = seed ^ base_addr;
            state_d = mode[0] ? StWr : StRd;
          end
        end
      end
      StWr: begin
        if (wbm_ack_i) begin
          cyc_d   = 1'b0;
          k_d     = k_inc;
          state_d = StWgap;
          // Next word's address/data/we settle during the gap, before the strobe rises.
          if (k_inc < count_q) begin
            adr_d = addr_of(base_q, k_inc);
            dat_d = seed_q ^ addr_of(base_q, k_inc);
          end else if (mode_q == 2'b11) begin
            we_d  = 1'b0;
            adr_d = base_q;
            dat_d = seed_q ^ base_q;
          end
        end
      end
      StWgap: begin
        if (k_q < count_q) begin
          cyc_d   = 1'b1;
          state_d = StWr;
        end else if (mode_q == 2'b11) begin
          k_d     = 16'd0;
          cyc_d   = 1'b1;
          state_d = StRd;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end
`ifdef WBM_TIMEOUT_EN
        wdog_d = '0;
`endif
      end
      StRd: begin
        if (wbm_ack_i) begin
          // dat_q holds the expected pattern word for the current read.
          if (wbm_dat_i != dat_q) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (err_q == 16'd0) ferr_d = adr_q;
          end
          cyc_d   = 1'b0;
          k_d     = k_inc;
          state_d = StRgap;
          if (k_inc < count_q) begin
            adr_d = addr_of(base_q, k_inc);
            dat_d = seed_q ^ addr_of(base_q, k_inc);
          end
        end
      end
      StRgap: begin
        if (k_q < count_q) begin
          cyc_d   = 1'b1;
          state_d = StRd;
        end else begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end
`ifdef WBM_TIMEOUT_EN
        wdog_d = '0;
`endif
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
`ifdef WBM_TIMEOUT_EN
    if ((state_q == StWr || state_q == StRd) && !wbm_ack_i) begin
      if (32'(wdog_q) + 32'd1 >= TIMEOUT) begin
        cyc_d   = 1'b0;
        tmo_d   = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = StDone;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
`endif
    sel_d = {4{cyc_d}};
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      k_q     <= '0;
      count_q <= '0;
      mode_q  <= '0;
      base_q  <= '0;
      seed_q  <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef WBM_TIMEOUT_EN
      wdog_q  <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
      seed_q  <= seed_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef WBM_TIMEOUT_EN
      wdog_q  <= wdog_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign wbm_cyc_o      = cyc_q;
  assign wbm_stb_o      = cyc_q;
  assign wbm_we_o       = we_q;
  assign wbm_sel_o      = sel_q;
  assign wbm_adr_o      = adr_q;
  assign wbm_dat_o      = dat_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_cnt        = err_q;
  assign first_err_addr = ferr_q;
`ifdef WBM_TIMEOUT_EN
  assign timeout_o      = tmo_q;
`else
  assign timeout_o      = 1'b0;
`endif

endmodule

// File: tb/tb_wb_seq_master.sv
// Self-checking bench for wb_seq_master: behavioural responder/monitor plus directed and
// randomized jobs compared against an arithmetic model of the address/data sequence.
module tb_wb_seq_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] base_addr, seed;
  logic [15:0] count;
  logic        cyc, stb, we, ack, busy, done, timeout_o;
  logic [3:0]  sel;
  logic [31:0] adr, dat, rdata, first_err_addr;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  wb_seq_master #(.TIMEOUT(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .mode(mode), .base_addr(base_addr),
    .count(count), .seed(seed), .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
    .wbm_sel_o(sel), .wbm_adr_o(adr), .wbm_dat_o(dat), .wbm_ack_i(ack), .wbm_dat_i(rdata),
    .busy(busy), .done(done), .err_cnt(err_cnt), .first_err_addr(first_err_addr),
    .timeout_o(timeout_o)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } txn_t;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Responder and bus monitor, all updated on the falling edge.
  logic [31:0] mem [logic [31:0]];
  bit          resp_en = 1'b1, stray = 1'b0, bad_en = 1'b0;
  logic [31:0] bad_adr = 32'h0;
  int          lat = 0, wcnt = 0;
  int          ncyc = 0, last_ack_at = 0, done_cnt = 0, stb_cycles = 0;
  bit          busy_seen = 1'b0, cyc_seen = 1'b0;
  txn_t        act_q[$];
  bit          p_ack = 1'b0, p_cyc = 1'b0, p_we = 1'b0;
  logic [31:0] p_adr = 32'h0, p_dat = 32'h0;

  initial begin
    ack   = 1'b0;
    rdata = 32'h0;
  end

  always @(negedge clk) begin
    ncyc++;
    if (done) done_cnt++;
    if (busy) busy_seen = 1'b1;
    if (cyc) cyc_seen = 1'b1;
    if (stb) stb_cycles++;
    check("stb_eq_cyc", 32'(stb), 32'(cyc));
    check("sel", 32'(sel), cyc ? 32'hF : 32'h0);
    if (p_ack) check("gap_after_ack", 32'(cyc), 32'h0);
    if (p_cyc && !p_ack && cyc) begin
      check("hold_adr", adr, p_adr);
      check("hold_dat", dat, p_dat);
      check("hold_we", 32'(we), 32'(p_we));
    end
    if (cyc && stb && resp_en) begin
      if (wcnt == lat) begin
        ack  = 1'b1;
        wcnt = 0;
      end else begin
        ack = 1'b0;
        wcnt++;
      end
    end else begin
      ack  = !cyc && stray;
      wcnt = 0;
    end
    rdata = 32'h0;
    if (ack && cyc) begin
      if (we) mem[adr] = dat;
      else begin
        rdata = mem.exists(adr) ? mem[adr] : 32'hDEAD_BEEF;
        if (bad_en && adr == bad_adr) rdata = rdata ^ 32'h1;
      end
      act_q.push_back('{we: we, adr: adr, dat: dat});
      last_ack_at = ncyc;
    end
    p_ack = ack && cyc;
    p_cyc = cyc;
    p_we  = we;
    p_adr = adr;
    p_dat = dat;
  end

  // One job: build the expected transaction list and error summary, run, compare.
  task automatic run_job(input logic [1:0] m, input logic [31:0] b, input logic [15:0] c,
                         input logic [31:0] s, input bit garble, input bit midstart);
    txn_t        exp_q[$];
    logic [31:0] pre[$];
    logic [31:0] a, rv;
    int          exp_err = 0;
    logic [31:0] exp_first = 32'h0;
    bit          trivial = (m == 2'b00) || (c == 16'd0);
    bit          got_done = 1'b0;
    if (!trivial) begin
      for (int k = 0; k < int'(c); k++) begin
        a = b + 32'(k) * 32'd4;
        rv = s ^ a;
        if (garble && ($urandom % 4 == 0)) rv = rv ^ ($urandom | 32'h1);
        pre.push_back(rv);
        if (m == 2'b10) mem[a] = rv;
        if (m[0]) exp_q.push_back('{we: 1'b1, adr: a, dat: s ^ a});
      end
      if (m[1]) begin
        for (int k = 0; k < int'(c); k++) begin
          a = b + 32'(k) * 32'd4;
          rv = (m == 2'b11) ? (s ^ a) : pre[k];
          if (bad_en && a == bad_adr) rv = rv ^ 32'h1;
          if (rv != (s ^ a)) begin
            if (exp_err == 0) exp_first = a;
            exp_err++;
          end
          exp_q.push_back('{we: 1'b0, adr: a, dat: 32'h0});
        end
      end
    end
    act_q.delete();
    done_cnt  = 0;
    busy_seen = 1'b0;
    cyc_seen  = 1'b0;
    @(posedge clk); #1;
    mode = m; base_addr = b; count = c; seed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_tmo_clear", 32'(timeout_o), 32'h0);
    if (trivial) begin
      check("triv_done", 32'(done), 32'h1);
      check("triv_busy", 32'(busy), 32'h0);
      check("triv_cyc", 32'(cyc), 32'h0);
      @(posedge clk); #1;
      check("triv_done_pulse", 32'(done), 32'h0);
      @(posedge clk); #1;
      check("triv_busy_seen", 32'(busy_seen), 32'h0);
      check("triv_cyc_seen", 32'(cyc_seen), 32'h0);
      check("triv_done_cnt", 32'(done_cnt), 32'h1);
    end else begin
      check("start_busy", 32'(busy), 32'h1);
      check("start_cyc", 32'(cyc), 32'h1);
      check("start_we", 32'(we), 32'(m[0]));
      check("start_adr", adr, b);
      for (int i = 0; i < 5000; i++) begin
        @(posedge clk); #1;
        if (midstart && i == 3) begin
          mode = 2'b10; count = 16'd1; base_addr = 32'h1000; start = 1'b1;
        end else begin
          start = 1'b0;
        end
        if (done) begin
          got_done = 1'b1;
          break;
        end
      end
      start = 1'b0;
      check("done_seen", 32'(got_done), 32'h1);
      check("done_busy_low", 32'(busy), 32'h0);
      check("done_latency", 32'(ncyc - last_ack_at), 32'h1);
      @(posedge clk); #1;
      check("done_pulse", 32'(done), 32'h0);
      check("done_cnt", 32'(done_cnt), 32'h1);
      check("err_cnt", 32'(err_cnt), 32'(exp_err));
      check("first_err_addr", first_err_addr, exp_first);
      check("timeout_o", 32'(timeout_o), 32'h0);
      check("txn_count", 32'(act_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
        check("txn_we", 32'(act_q[i].we), 32'(exp_q[i].we));
        check("txn_adr", act_q[i].adr, exp_q[i].adr);
        if (exp_q[i].we) check("txn_dat", act_q[i].dat, exp_q[i].dat);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'b00; base_addr = 32'h0; count = 16'h0; seed = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cyc", 32'(cyc), 32'h0);
    check("rst_we", 32'(we), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_adr", adr, 32'h0);
    check("rst_dat", dat, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err_cnt), 32'h0);
    check("rst_ferr", first_err_addr, 32'h0);
    check("rst_tmo", 32'(timeout_o), 32'h0);
    rst = 1'b0;

    // Write then read back, zero-wait responder.
    run_job(2'b11, 32'h3800_0000, 16'd4, 32'hA5A5_0000, 1'b0, 1'b0);
    // Read-only with one corrupted word at k = 2.
    bad_en = 1'b1; bad_adr = 32'h8;
    run_job(2'b10, 32'h0, 16'd4, 32'h1234_5678, 1'b0, 1'b0);
    bad_en = 1'b0;
    // Degenerate starts.
    run_job(2'b11, 32'h4000, 16'd0, 32'h1, 1'b0, 1'b0);
    run_job(2'b00, 32'h4000, 16'd5, 32'h1, 1'b0, 1'b0);
    // Address wrap.
    run_job(2'b01, 32'hFFFF_FFF8, 16'd3, 32'h0F0F_0F0F, 1'b0, 1'b0);
    // Slow responder, stray acks in idle/gap cycles, start pulsed mid-run.
    lat = 5; stray = 1'b1;
    run_job(2'b11, 32'h0000_2000, 16'd3, 32'hCAFE_F00D, 1'b0, 1'b1);
    stray = 1'b0;

    for (int j = 0; j < 12; j++) begin
      logic [1:0]  m;
      logic [15:0] c;
      logic [31:0] b;
      m = 2'($urandom_range(1, 3));
      c = 16'($urandom_range(1, 6));
      b = $urandom;
      lat = $urandom_range(0, 3);
      bad_en = ($urandom % 2) == 1;
      bad_adr = b + 32'($urandom_range(0, 5)) * 32'd4;
      run_job(m, b, c, $urandom, 1'b1, 1'b0);
    end
    bad_en = 1'b0; lat = 0;

    // Reset mid-write: outputs return to reset values one edge later, no done pulse.
    lat = 20;
    @(posedge clk); #1;
    mode = 2'b01; base_addr = 32'h500; count = 16'd2; seed = 32'h77; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_cyc_before", 32'(cyc), 32'h1);
    done_cnt = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_cyc", 32'(cyc), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_adr", adr, 32'h0);
    check("mid_rst_dat", dat, 32'h0);
    check("mid_rst_we", 32'(we), 32'h0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_no_done", 32'(done_cnt), 32'h0);
    lat = 0;

`ifdef WBM_TIMEOUT_EN
    begin
      bit got_done = 1'b0;
      resp_en = 1'b0;
      done_cnt = 0;
      @(posedge clk); #1;
      mode = 2'b01; base_addr = 32'h900; count = 16'd2; seed = 32'h5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      stb_cycles = 0;
      for (int i = 0; i < 200; i++) begin
        @(posedge clk); #1;
        if (done) begin
          got_done = 1'b1;
          break;
        end
      end
      check("tmo_done_seen", 32'(got_done), 32'h1);
      check("tmo_stb_cycles", 32'(stb_cycles), 32'd16);
      check("tmo_flag", 32'(timeout_o), 32'h1);
      check("tmo_cyc_low", 32'(cyc), 32'h0);
      resp_en = 1'b1;
      run_job(2'b01, 32'h900, 16'd1, 32'h5, 1'b0, 1'b0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
